// File: rtl/stg_2_id_pipe.sv
// Instruction-decode pipeline stage with valid/ready handshake,
// flush, scoreboard RAW interlock and a saturating stall counter.
module stg_2_id_pipe #(
   parameter int INSTR_W     = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int VALUE_W     = 32,
   parameter int ALU_OP_W    = 4,
   parameter int WB_DEPTH    = 3,
   parameter bit ZERO_REG    = 1'b1,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   s_if_valid,
   input  logic [INSTR_W-1:0]     r_id_instr,
   output logic                   s_id_ready,
   input  logic                   flush,
   input  logic                   s_ex_ready,
   output logic [REG_ADDR_W-1:0]  s_id_rs1,
   output logic [REG_ADDR_W-1:0]  s_id_rs2,
   output logic                   r_ex_valid,
   output logic [ALU_OP_W-1:0]    r_ex_aluop,
   output logic [REG_ADDR_W-1:0]  r_ex_rd,
   output logic [VALUE_W-1:0]     r_ex_imm,
   output logic [INSTR_W-1:0]     r_ex_instr,
   output logic                   r_ex_RegWrite,
   output logic                   r_ex_PrintValue,
   output logic                   s_id_stall,
   output logic [STALL_CNT_W-1:0] r_id_stall_cnt
);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_PRT = 7'b0001011;

   // Tracker holds producers that left EX but have not yet written back.
   localparam int TRK = (WB_DEPTH > 1) ? WB_DEPTH - 1 : 1;

   logic [6:0]            opcode;
   logic [ALU_OP_W-1:0]   dec_aluop;
   logic [REG_ADDR_W-1:0] dec_rd;
   logic [VALUE_W-1:0]    dec_imm;
   logic                  dec_regw;
   logic                  dec_print;

   logic [TRK-1:0]        trk_v;
   logic [REG_ADDR_W-1:0] trk_rd [TRK];

   logic pend_hit;
   logic hazard;
   logic accept;

   assign opcode = r_id_instr[6:0];

   // Instruction field decode (register fields, aluop, imm, controls).
   always_comb begin
      s_id_rs1  = REG_ADDR_W'(r_id_instr[19:15]);
      s_id_rs2  = REG_ADDR_W'(r_id_instr[24:20]);
      dec_rd    = REG_ADDR_W'(r_id_instr[11:7]);
      dec_aluop = ALU_OP_W'({r_id_instr[30], r_id_instr[14:12]});
      dec_regw  = 1'b0;
      dec_print = 1'b0;
      dec_imm   = {{(VALUE_W-12){r_id_instr[31]}},
                   r_id_instr[31:20]};
      unique case (opcode)
         OP_R, OP_I, OP_LD: dec_regw = 1'b1;
         OP_LUI: begin
            dec_regw = 1'b1;
            dec_imm  = VALUE_W'({r_id_instr[31:12], 12'b0});
         end
         OP_ST: begin
            dec_imm = {{(VALUE_W-12){r_id_instr[31]}},
                       r_id_instr[31:25], r_id_instr[11:7]};
         end
         OP_PRT: dec_print = 1'b1;
         default: dec_regw = 1'b0;
      endcase
   end

   function automatic logic hit(
      input logic [REG_ADDR_W-1:0] rd,
      input logic [REG_ADDR_W-1:0] a,
      input logic [REG_ADDR_W-1:0] b
   );
      logic zero;
      zero = ZERO_REG && (rd == '0);
      return ((rd == a) || (rd == b)) && !zero;
   endfunction

   // Match both source fields against every pending write.
   always_comb begin
      pend_hit = 1'b0;
      if (r_ex_valid && r_ex_RegWrite &&
          hit(r_ex_rd, s_id_rs1, s_id_rs2))
         pend_hit = 1'b1;
      for (int i = 0; i < TRK; i++) begin
         if (trk_v[i] && hit(trk_rd[i], s_id_rs1, s_id_rs2))
            pend_hit = 1'b1;
      end
   end

   assign hazard     = s_if_valid && pend_hit;
   assign s_id_stall = hazard;
   assign s_id_ready = !hazard && !flush &&
                       (!r_ex_valid || s_ex_ready);
   assign accept     = s_if_valid && s_id_ready;

   // Writeback tracker: advances with the pipe, flushed EX never enters.
   always_ff @(posedge clock) begin
      if (!reset) begin
         trk_v <= '0;
         for (int i = 0; i < TRK; i++) trk_rd[i] <= '0;
      end else if (s_ex_ready) begin
         trk_v[0]  <= (WB_DEPTH > 1) && r_ex_valid &&
                      r_ex_RegWrite && !flush;
         trk_rd[0] <= r_ex_rd;
         for (int i = 1; i < TRK; i++) begin
            trk_v[i]  <= trk_v[i-1];
            trk_rd[i] <= trk_rd[i-1];
         end
      end
   end

   // EX register: load on accept, bubble on advance/flush, else hold.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_ex_valid      <= 1'b0;
         r_ex_aluop      <= '0;
         r_ex_rd         <= '0;
         r_ex_imm        <= '0;
         r_ex_instr      <= '0;
         r_ex_RegWrite   <= 1'b0;
         r_ex_PrintValue <= 1'b0;
      end else if (accept) begin
         r_ex_valid      <= 1'b1;
         r_ex_aluop      <= dec_aluop;
         r_ex_rd         <= dec_rd;
         r_ex_imm        <= dec_imm;
         r_ex_instr      <= r_id_instr;
         r_ex_RegWrite   <= dec_regw;
         r_ex_PrintValue <= dec_print;
      end else if (s_ex_ready || flush) begin
         r_ex_valid      <= 1'b0;
         r_ex_RegWrite   <= 1'b0;
         r_ex_PrintValue <= 1'b0;
      end
   end

   // Count hazard stall cycles, saturating at all-ones.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_id_stall_cnt <= '0;
      end else if (hazard && !flush && !(&r_id_stall_cnt)) begin
         r_id_stall_cnt <= r_id_stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_stg_2_id_pipe.sv
// Bench for stg_2_id_pipe: directed vector table plus random
// traffic checked against an in-flight-write reference model.
module tb_stg_2_id_pipe;

   localparam int WB = 3;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_PRT = 7'b0001011;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   logic          clock = 1'b0;
   logic          reset;
   logic          s_if_valid;
   logic [31:0]   r_id_instr;
   logic          s_id_ready;
   logic          flush;
   logic          s_ex_ready;
   logic [4:0]    s_id_rs1, s_id_rs2;
   logic          r_ex_valid;
   logic [3:0]    r_ex_aluop;
   logic [4:0]    r_ex_rd;
   logic [31:0]   r_ex_imm;
   logic [31:0]   r_ex_instr;
   logic          r_ex_RegWrite, r_ex_PrintValue;
   logic          s_id_stall;
   logic [CW-1:0] r_id_stall_cnt;

   stg_2_id_pipe #(
      .INSTR_W(32), .REG_ADDR_W(5), .VALUE_W(32), .ALU_OP_W(4),
      .WB_DEPTH(WB), .ZERO_REG(1'b1), .STALL_CNT_W(CW)
   ) dut (
      .clock(clock), .reset(reset),
      .s_if_valid(s_if_valid), .r_id_instr(r_id_instr),
      .s_id_ready(s_id_ready), .flush(flush),
      .s_ex_ready(s_ex_ready),
      .s_id_rs1(s_id_rs1), .s_id_rs2(s_id_rs2),
      .r_ex_valid(r_ex_valid), .r_ex_aluop(r_ex_aluop),
      .r_ex_rd(r_ex_rd), .r_ex_imm(r_ex_imm),
      .r_ex_instr(r_ex_instr), .r_ex_RegWrite(r_ex_RegWrite),
      .r_ex_PrintValue(r_ex_PrintValue),
      .s_id_stall(s_id_stall), .r_id_stall_cnt(r_id_stall_cnt)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  aluop;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic        regw, pv;
   } dec_t;

   typedef struct {
      logic [4:0] rd;
      int         left;
   } inf_t;

   typedef struct {
      logic        v;
      logic [31:0] ins;
      logic        fl, er;
      logic        e_rdy, e_stl, e_exv;
      logic [4:0]  e_rd;
      int          e_cnt;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic        mv, mregw, mpv;
   logic [3:0]  maluop;
   logic [4:0]  mrd;
   logic [31:0] mimm, minstr;
   int          mcnt;
   inf_t        q[$];

   // per-cycle values shared between drive and tick
   dec_t cd;
   logic ch, crdy, cfl, cer, crst, cv;
   logic [31:0] cins;

   vec_t tbl[64];
   int   n;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0h want %0h",
                  nm, $time, act, exp);
      end
   endtask

   function automatic dec_t dec(input logic [31:0] i);
      dec_t d;
      logic [6:0] o;
      o = i[6:0];
      d.rd    = i[11:7];
      d.rs1   = i[19:15];
      d.rs2   = i[24:20];
      d.aluop = {i[30], i[14:12]};
      d.regw  = (o == OP_R) || (o == OP_I) ||
                (o == OP_LD) || (o == OP_LUI);
      d.pv    = (o == OP_PRT);
      if (o == OP_LUI)     d.imm = {i[31:12], 12'h000};
      else if (o == OP_ST) d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      else                 d.imm = {{20{i[31]}}, i[31:20]};
      return d;
   endfunction

   function automatic logic reads(input logic [4:0] r,
                                  input logic [4:0] a,
                                  input logic [4:0] b);
      return (r != 5'd0) && (r == a || r == b);
   endfunction

   // Any write still in flight (EX or not yet written back)?
   function automatic logic pend(input logic [4:0] a,
                                 input logic [4:0] b);
      logic p;
      p = mv && mregw && reads(mrd, a, b);
      foreach (q[k]) if (reads(q[k].rd, a, b)) p = 1'b1;
      return p;
   endfunction

   function automatic logic [31:0] op_r(input logic [4:0] rd,
                                        input logic [4:0] a,
                                        input logic [4:0] b);
      return {7'b0, b, a, 3'b000, rd, OP_R};
   endfunction

   task automatic drive(input logic r, input logic v,
                        input logic [31:0] ins,
                        input logic fl, input logic er);
      reset = r; s_if_valid = v; r_id_instr = ins;
      flush = fl; s_ex_ready = er;
      crst = r; cv = v; cins = ins; cfl = fl; cer = er;
      #1;
      cd   = dec(ins);
      ch   = v && pend(cd.rs1, cd.rs2);
      crdy = !ch && !fl && (!mv || er);
      chk("id_ready", s_id_ready, crdy);
      chk("id_stall", s_id_stall, ch);
      chk("id_rs1", s_id_rs1, cd.rs1);
      chk("id_rs2", s_id_rs2, cd.rs2);
   endtask

   task automatic tick();
      inf_t nq[$];
      if (!crst) begin
         mv = 0; mregw = 0; mpv = 0; maluop = 0; mrd = 0;
         mimm = 0; minstr = 0; mcnt = 0; q.delete();
      end else begin
         if (cer) begin
            foreach (q[k])
               if (q[k].left > 1)
                  nq.push_back('{q[k].rd, q[k].left - 1});
            q = nq;
            if (mv && mregw && !cfl && WB > 1)
               q.push_back('{mrd, WB - 1});
         end
         if (ch && !cfl && mcnt < CMAX) mcnt++;
         if (cv && crdy) begin
            mv = 1; mregw = cd.regw; mpv = cd.pv;
            maluop = cd.aluop; mrd = cd.rd; mimm = cd.imm;
            minstr = cins;
         end else if (cer || cfl) begin
            mv = 0; mregw = 0; mpv = 0;
         end
      end
      @(posedge clock);
      #1;
      chk("ex_valid", r_ex_valid, mv);
      chk("ex_regw", r_ex_RegWrite, mregw);
      chk("ex_print", r_ex_PrintValue, mpv);
      chk("ex_aluop", r_ex_aluop, maluop);
      chk("ex_rd", r_ex_rd, mrd);
      chk("ex_imm", r_ex_imm, mimm);
      chk("ex_instr", r_ex_instr, minstr);
      chk("stall_cnt", r_id_stall_cnt, mcnt);
   endtask

   task automatic row(input logic v, input logic [31:0] ins,
                      input logic fl, input logic er,
                      input logic rdy, input logic stl,
                      input logic exv, input logic [4:0] rd,
                      input int cnt);
      tbl[n] = '{v, ins, fl, er, rdy, stl, exv, rd, cnt};
      n++;
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [31:0] i;
      logic [6:0]  ops [7];
      ops = '{OP_R, OP_I, OP_LD, OP_LUI, OP_ST, OP_PRT, OP_BR};
      i = $urandom;
      i[6:0]   = ops[$urandom_range(0, 6)];
      i[11:7]  = 5'($urandom_range(0, 3));
      i[19:15] = 5'($urandom_range(0, 3));
      i[24:20] = 5'($urandom_range(0, 3));
      return i;
   endfunction

   initial begin
      n = 0;
      // streaming, disjoint registers
      row(1, op_r(1, 2, 3),    0, 1, 1, 0, 1, 1, 0);
      row(1, op_r(4, 9, 10),   0, 1, 1, 0, 1, 4, 0);
      row(1, op_r(11, 12, 13), 0, 1, 1, 0, 1, 11, 0);
      row(1, op_r(14, 15, 16), 0, 1, 1, 0, 1, 14, 0);
      // RAW on x5 via rs2: exactly WB stall cycles
      row(1, op_r(5, 17, 18),  0, 1, 1, 0, 1, 5, 0);
      for (int k = 1; k <= 3; k++)
         row(1, op_r(19, 20, 5), 0, 1, 0, 1, 0, 5, k);
      row(1, op_r(19, 20, 5),  0, 1, 1, 0, 1, 19, 3);
      // x0 never interlocks
      row(1, op_r(0, 21, 22),  0, 1, 1, 0, 1, 0, 3);
      row(1, op_r(23, 24, 0),  0, 1, 1, 0, 1, 23, 3);
      // backpressure only: held, uncounted
      for (int k = 0; k < 4; k++)
         row(1, op_r(25, 26, 27), 0, 0, 0, 0, 1, 23, 3);
      row(1, op_r(25, 26, 27), 0, 1, 1, 0, 1, 25, 3);
      // flush kills the x7 producer
      row(1, op_r(7, 28, 29),  0, 1, 1, 0, 1, 7, 3);
      row(1, op_r(30, 7, 1),   1, 1, 0, 1, 0, 7, 3);
      row(1, op_r(30, 7, 1),   0, 1, 1, 0, 1, 30, 3);
      // hazard under backpressure: counter saturates
      row(1, op_r(9, 0, 0),    0, 1, 1, 0, 1, 9, 3);
      for (int k = 1; k <= 20; k++)
         row(1, op_r(2, 9, 9), 0, 0, 0, 1, 1, 9,
             (3 + k > 15) ? 15 : 3 + k);
      row(1, op_r(2, 9, 9),    0, 1, 0, 1, 0, 9, 15);
      row(1, op_r(2, 9, 9),    0, 1, 0, 1, 0, 9, 15);
      row(1, op_r(2, 9, 9),    0, 1, 0, 1, 0, 9, 15);
      row(1, op_r(2, 9, 9),    0, 1, 1, 0, 1, 2, 15);

      reset = 0; s_if_valid = 1; r_id_instr = 32'hDEADBEEF;
      flush = 0; s_ex_ready = 1;
      crst = 0; cv = 1; cins = 0; cfl = 0; cer = 1;
      cd = dec(0); ch = 0; crdy = 0;
      tick();
      for (int k = 0; k < 2; k++) begin
         drive(0, 1, $urandom, 0, 1);
         tick();
      end
      chk("rst_ex_valid", r_ex_valid, 0);
      chk("rst_ex_instr", r_ex_instr, 0);
      chk("rst_cnt", r_id_stall_cnt, 0);

      for (int k = 0; k < n; k++) begin
         drive(1, tbl[k].v, tbl[k].ins, tbl[k].fl, tbl[k].er);
         chk($sformatf("tbl%0d_ready", k), s_id_ready,
             tbl[k].e_rdy);
         chk($sformatf("tbl%0d_stall", k), s_id_stall,
             tbl[k].e_stl);
         tick();
         chk($sformatf("tbl%0d_exv", k), r_ex_valid, tbl[k].e_exv);
         chk($sformatf("tbl%0d_rd", k), r_ex_rd, tbl[k].e_rd);
         chk($sformatf("tbl%0d_cnt", k), r_id_stall_cnt,
             tbl[k].e_cnt);
      end

      // reset in the middle of a stall discards pending state
      drive(1, 1, op_r(6, 1, 1), 0, 1);
      tick();
      drive(1, 1, op_r(8, 6, 6), 0, 1);
      tick();
      drive(0, 1, op_r(8, 6, 6), 0, 1);
      tick();
      drive(1, 1, op_r(8, 6, 6), 0, 1);
      chk("post_rst_ready", s_id_ready, 1);
      tick();
      chk("post_rst_rd", r_ex_rd, 8);

      for (int k = 0; k < 1500; k++) begin
         drive(($urandom_range(0, 99) != 0),
               ($urandom_range(0, 4) != 0), rnd_instr(),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 3) != 0));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
